// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan controller for an 8-digit common-anode
// seven-segment display. It steps the digit select S through 0..7 and
// decodes the returned digit value into active-low segments. Every digit
// change has a one-cycle anode-off gap so the multiplexer can settle.
module seg_scan #(
  parameter int DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] BLANK,
  input  logic [3:0] Y,
  input  logic       DP,
  output logic [2:0] S,
  output logic [6:0] SEG,
  output logic       DP_O,
  output logic [7:0] AN
);

  localparam int PW = $clog2(DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  typedef enum logic {
    BLNK = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [PW-1:0]   presc_r;
  logic [PW-1:0]   presc_s;
  logic [2:0]      sel_s;
  logic [6:0]      seg_s;
  logic            dp_s;
  logic [7:0]      an_s;

  // Hex digit to active-low segment pattern, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'b0000001;
      4'h1:    p = 7'b1001111;
      4'h2:    p = 7'b0010010;
      4'h3:    p = 7'b0000110;
      4'h4:    p = 7'b1001100;
      4'h5:    p = 7'b0100100;
      4'h6:    p = 7'b0100000;
      4'h7:    p = 7'b0001111;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0000100;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b1100000;
      4'hC:    p = 7'b0110001;
      4'hD:    p = 7'b1000010;
      4'hE:    p = 7'b0110000;
      4'hF:    p = 7'b0111000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Active-low anode pattern for one digit, or all off when it is masked.
  function automatic logic [7:0] anode(input logic [2:0] idx, input logic masked);
    logic [7:0] a;
    if (masked) begin
      a = 8'hFF;
    end else begin
      a = ~(8'h01 << idx);
    end
    return a;
  endfunction

  // Next-state and next-output logic; EN low keeps everything as it is.
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    sel_s   = S;
    seg_s   = SEG;
    dp_s    = DP_O;
    an_s    = AN;
    if (EN) begin
      case (state_r)
        BLNK: begin
          // Multiplexer has settled on S: latch its digit and light it.
          seg_s   = decode(Y);
          dp_s    = DP;
          an_s    = anode(S, BLANK[S]);
          presc_s = {PW{1'b0}};
          state_s = SHOW;
        end
        SHOW: begin
          if (presc_r == LAST) begin
            // Advance to the next digit with anodes dark for one cycle.
            sel_s   = 3'(S + 3'd1);
            an_s    = 8'hFF;
            presc_s = {PW{1'b0}};
            state_s = BLNK;
          end else begin
            presc_s = PW'(presc_r + {{(PW-1){1'b0}}, 1'b1});
          end
        end
        default: begin
          an_s    = 8'hFF;
          presc_s = {PW{1'b0}};
          state_s = BLNK;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= BLNK;
      presc_r <= {PW{1'b0}};
      S       <= 3'd0;
      SEG     <= 7'h7F;
      DP_O    <= 1'b1;
      AN      <= 8'hFF;
    end else begin
      state_r <= state_s;
      presc_r <= presc_s;
      S       <= sel_s;
      SEG     <= seg_s;
      DP_O    <= dp_s;
      AN      <= an_s;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: an edge-count model of the scan checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seg_scan;

  localparam int DIV  = 4;
  localparam int SLOT = DIV + 1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] blank;
  logic [3:0] y;
  logic       dp;
  logic [2:0] s;
  logic [6:0] seg;
  logic       dp_o;
  logic [7:0] an;

  logic [3:0] digit_val [8];
  logic       dp_val    [8];

  int passed = 0;
  int total  = 0;

  // Reference decode table, digits 0..F.
  logic [6:0] dec_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state: enabled edges since reset and the expected outputs.
  int         m_e   = 0;
  logic [2:0] m_s   = 3'd0;
  logic [7:0] m_an  = 8'hFF;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp  = 1'b1;

  seg_scan #(.DIV(DIV)) dut (
    .CLK  (clk),
    .RST  (rst),
    .EN   (en),
    .BLANK(blank),
    .Y    (y),
    .DP   (dp),
    .S    (s),
    .SEG  (seg),
    .DP_O (dp_o),
    .AN   (an)
  );

  // Combinational 8-to-1 digit multiplexer.
  assign y  = digit_val[s];
  assign dp = dp_val[s];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t, e=%0d)", name, act, exp, $time, m_e);
    end else begin
      passed++;
    end
  endtask

  // Model: after e enabled edges, digit e/SLOT mod 8 is selected; phase 0
  // is the dark gap, phase 1 latches and lights the digit.
  always @(posedge clk) begin : model
    int ne;
    int ph;
    int d;
    if (rst) begin
      m_e   <= 0;
      m_s   <= 3'd0;
      m_an  <= 8'hFF;
      m_seg <= 7'h7F;
      m_dp  <= 1'b1;
    end else if (en) begin
      ne = m_e + 1;
      ph = ne % SLOT;
      d  = (ne / SLOT) % 8;
      m_e <= ne;
      m_s <= 3'(d);
      if (ph == 1) begin
        m_seg <= dec_tab[digit_val[d]];
        m_dp  <= dp_val[d];
        m_an  <= blank[d] ? 8'hFF : ~(8'h01 << d);
      end else if (ph == 0) begin
        m_an <= 8'hFF;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("S", {29'd0, s}, {29'd0, m_s});
    check("AN", {24'd0, an}, {24'd0, m_an});
    check("SEG", {25'd0, seg}, {25'd0, m_seg});
    check("DP_O", {31'd0, dp_o}, {31'd0, m_dp});
    check("one_anode", {31'd0, ($countones(~an) <= 1)}, 32'd1);
  end

  task automatic goto(input int t);
    int b;
    b = 0;
    while (m_e != t && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (m_e != t) check("goto_timeout", m_e, t);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    blank = 8'h00;
    for (int i = 0; i < 8; i++) begin
      digit_val[i] = 4'(i);
      dp_val[i]    = (i != 2);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Free run after reset.
    goto(1);
    check("first_an", {24'd0, an}, 32'hFE);
    check("first_s", {29'd0, s}, 32'd0);
    check("first_seg", {25'd0, seg}, 32'b0000001);
    goto(5);
    check("gap_an", {24'd0, an}, 32'hFF);
    check("gap_s", {29'd0, s}, 32'd1);
    goto(6);
    check("d1_an", {24'd0, an}, 32'hFD);
    check("d1_seg", {25'd0, seg}, 32'b1001111);
    goto(11);
    check("d2_an", {24'd0, an}, 32'hFB);
    check("d2_dp", {31'd0, dp_o}, 32'd0);
    goto(16);
    check("d3_an", {24'd0, an}, 32'hF7);
    check("d3_dp", {31'd0, dp_o}, 32'd1);
    goto(36);
    check("d7_an", {24'd0, an}, 32'h7F);
    check("d7_s", {29'd0, s}, 32'd7);
    goto(40);
    check("wrap_s", {29'd0, s}, 32'd0);
    check("wrap_an", {24'd0, an}, 32'hFF);
    goto(41);

    // Decode sweep: second pass shows values 8..F.
    for (int i = 0; i < 8; i++) digit_val[i] = 4'(8 + i);
    goto(51);
    check("dec_A", {25'd0, seg}, 32'b0001000);
    goto(61);
    check("dec_C", {25'd0, seg}, 32'b0110001);
    goto(71);
    check("dec_E", {25'd0, seg}, 32'b0110000);
    goto(76);
    check("dec_F", {25'd0, seg}, 32'b0111000);

    // Late data change on digit 0 during its SHOW.
    goto(81);
    check("late_before", {25'd0, seg}, 32'b0000000);
    goto(82);
    digit_val[0] = 4'h5;
    goto(84);
    check("late_held", {25'd0, seg}, 32'b0000000);
    goto(121);
    check("late_next", {25'd0, seg}, 32'b0100100);

    // Enable freeze mid-SHOW of digit 3.
    goto(137);
    en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("frz_s", {29'd0, s}, 32'd3);
      check("frz_an", {24'd0, an}, 32'hF7);
    end
    en = 1'b1;
    goto(139);
    check("resume_lit", {24'd0, an}, 32'hF7);
    goto(140);
    check("resume_gap", {24'd0, an}, 32'hFF);
    check("resume_s", {29'd0, s}, 32'd4);

    // Blank mask on digits 0 and 7.
    blank = 8'h81;
    goto(161);
    check("blk0_an", {24'd0, an}, 32'hFF);
    check("blk0_s", {29'd0, s}, 32'd0);
    goto(176);
    check("blk3_an", {24'd0, an}, 32'hF7);
    goto(191);
    check("blk6_an", {24'd0, an}, 32'hBF);
    goto(196);
    check("blk7_an", {24'd0, an}, 32'hFF);
    check("blk7_s", {29'd0, s}, 32'd7);
    goto(197);
    blank = 8'h00;
    goto(198);
    check("blk_midslot", {24'd0, an}, 32'hFF);
    goto(201);
    check("unblk0_an", {24'd0, an}, 32'hFE);

    // Reset mid-SHOW of digit 5.
    goto(227);
    check("pre_rst_an", {24'd0, an}, 32'hDF);
    rst = 1'b1;
    @(negedge clk);
    check("rst_s", {29'd0, s}, 32'd0);
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_an", {24'd0, an}, 32'hFE);
    check("post_rst_seg", {25'd0, seg}, 32'b0100100);
    goto(46);
    check("post_rst_d1", {24'd0, an}, 32'hFD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scan controller for the 8-digit common-anode seven-segment display. It drives the 3-bit digit-select bus `S` into the 8-to-1 digit multiplexer and consumes the multiplexer's 4-bit `Y` and `DP` return. It decodes the returned digit to segment patterns and drives the active-low anode enables, cycling digit 0 to digit 7 continuously. A one-cycle anode blanking gap on every digit change suppresses ghosting.

## Interface
- `DIV`, default 50000: clock cycles a digit stays lit per slot; legal range ≥ 1; prescaler width is `$clog2(DIV+1)`.
- `CLK`  input  1  system clock; all state changes on its rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `EN`  input  1  scan enable; low freezes the scan with all outputs held.
- `BLANK`  input  8  per-digit blank mask; `BLANK[i]=1` keeps anode `i` off during its slot.
- `Y`  input  4  digit value returned by the multiplexer for the current `S`; combinational from `S`.
- `DP`  input  1  active-low decimal point returned by the multiplexer for the current `S`.
- `S`  output  3  registered digit select to the multiplexer.
- `SEG`  output  7  active-low segments; `SEG[6]`=a … `SEG[0]`=g.
- `DP_O`  output  1  active-low decimal point to the display.
- `AN`  output  8  active-low anode enables; `AN[i]` drives digit `i`.

## Operation
- State machine with two states:
  - BLNK: anodes are off while the multiplexer settles on the new `S`.
  - SHOW: the digit is lit.
- Reset values (all registered outputs): `S`=0, `AN`=8'hFF, `SEG`=7'h7F, `DP_O`=1, prescaler=0, state=BLNK.
- BLNK, `EN`=1, one clock:
  - `SEG` <= decode(`Y`), `DP_O` <= `DP`.
  - `AN` <= 8'hFF if `BLANK[S]`, else all ones except bit `S` low.
  - Prescaler <= 0, state <= SHOW.
- SHOW, `EN`=1:
  - Prescaler increments each cycle.
  - On the cycle where prescaler == `DIV`-1: `S` <= `S`+1 (7 wraps to 0), `AN` <= 8'hFF, prescaler <= 0, state <= BLNK.
  - `SEG` and `DP_O` hold their values into BLNK; they are dark because `AN` is all off.
- `EN`=0 in either state: prescaler, `S`, state, `SEG`, `DP_O` and `AN` all hold. Re-asserting `EN` resumes from the held point with no extra cycles.
- Decode `Y` to `SEG` (active-low a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- `Y` and `DP` are sampled only in the BLNK cycle. Changes on `Y` or `DP` during SHOW do not reach `SEG` or `DP_O` until that digit's next slot.
- `BLANK` is sampled only in the BLNK cycle. A mid-slot change of `BLANK` takes effect at the next slot.
- `RST` overrides `EN` and every state. Asserted mid-slot, it returns all outputs to their reset values on the next edge.

## Timing
- Slot length = `DIV`+1 cycles: 1 BLNK cycle plus `DIV` SHOW cycles.
- Frame length = 8·(`DIV`+1) cycles.
- `S` changes on the same edge that `AN` goes to 8'hFF. `AN` enables the new digit exactly one edge later, together with `SEG` and `DP_O`.
- No cycle ever has two anode bits low. Across a digit change, `AN` passes through 8'hFF for exactly one cycle.
- First lit digit after reset deassertion (`EN`=1): `AN`=8'hFE appears on the first edge after `RST` falls, showing digit 0.
- `DIV`=1: each digit is lit for one cycle and `AN` alternates between 8'hFF and a single low bit.
- `Y` must be stable within one clock of an `S` change; the multiplexer is combinational, so this holds.

## Test plan
- Reset then free run: `DIV`=4, `EN`=1, `BLANK`=0, multiplexer model digits 0..7 with `DP` low on digit 2 only.
  - `AN` sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles with one FF cycle between.
  - `S` wraps 7→0 after 40 cycles.
  - `DP_O`=0 only while `AN`=FB.
  - `SEG` on digit 1 reads 1001111.
- Decode sweep: drive digit values 0..F over two frames → `SEG` matches the full decode list above for all 16 values.
- Enable freeze: deassert `EN` for 10 cycles mid-SHOW on digit 3 → `S`=3, `AN`=F7 and prescaler held for all 10 cycles. After re-assertion the remaining SHOW cycles of the slot complete.
- Blank mask: `BLANK`=8'h81 → `AN` stays FF during the slots of digits 0 and 7 while `S` still steps through 0 and 7. Other digits are unaffected.
- Reset mid-operation: assert `RST` during SHOW of digit 5 → next edge gives `S`=0, `AN`=FF, `SEG`=7F, `DP_O`=1. After release, digit 0 is lit after exactly one edge.
- Late data change: change `Y` for the current digit during SHOW → `SEG` unchanged until the same digit's next slot, 8·(`DIV`+1) cycles later.
